// File: rtl/spi_write_sequencer_if.sv
// spi_write_sequencer_if: valid/ready register-write port between the serial sequencer and the register file.
interface spi_write_sequencer_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_valid;
   logic                  wr_ready;
   modport master (output wr_addr, wr_data, wr_valid, input wr_ready);
   modport slave  (input wr_addr, wr_data, wr_valid, output wr_ready);
endinterface

// File: rtl/spi_write_sequencer.sv
// spi_write_sequencer: deserializes 3-wire MCU frames (address header + auto-incrementing words) into valid/ready writes.
// Optional saturating abort/overflow counters are enabled with SPI_STATUS_COUNTERS_EN.
module spi_write_sequencer #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic sclk_in,
   input  logic mosi_in,
   input  logic csn_in,
   input  logic clr_status,
   spi_write_sequencer_if.master wr,
   output logic busy,
   output logic abort_pulse,
   output logic overflow
`ifdef SPI_STATUS_COUNTERS_EN
   ,
   output logic [7:0] abort_count,
   output logic [7:0] overflow_count
`endif
);
   localparam int MW = DATA_WIDTH > ADDR_WIDTH ? DATA_WIDTH : ADDR_WIDTH;
   localparam int CW = $clog2(MW);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   state_t                r_state, w_state_nx;
   logic [SYNC_STAGES-1:0] r_sclk_s, r_mosi_s, r_csn_s, r_fill;
   logic                  r_sclk_q, r_csn_q, r_armed;
   logic                  w_sclk, w_mosi, w_csn, w_sclk_rise, w_csn_fall, w_csn_rise;
   logic [CW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_shift, w_shift_nx, r_data;
   logic [ADDR_WIDTH-1:0] r_ptr, r_addr;
   logic                  r_valid, r_abort, r_ovf;
   logic                  w_sample, w_last, w_hdr_done, w_word_done, w_abort, w_load, w_drop;
   assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_s[SYNC_STAGES-1];
   assign w_csn       = r_csn_s[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk & ~r_sclk_q;
   assign w_csn_rise  = w_csn & ~r_csn_q;
   // a frame needs a genuinely observed high csn first, so csn held low through reset never starts one
   assign w_csn_fall  = ~w_csn & r_csn_q & r_armed;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_sclk_s <= '0;
         r_mosi_s <= '0;
         r_csn_s  <= '1;
         r_fill   <= '0;
         r_sclk_q <= 1'b0;
         r_csn_q  <= 1'b1;
         r_armed  <= 1'b0;
      end else begin
         r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], sclk_in};
         r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], mosi_in};
         r_csn_s  <= {r_csn_s[SYNC_STAGES-2:0], csn_in};
         r_fill   <= {r_fill[SYNC_STAGES-2:0], 1'b1};
         r_sclk_q <= w_sclk;
         r_csn_q  <= w_csn;
         r_armed  <= r_armed | (r_fill[SYNC_STAGES-1] & w_csn);
      end
   end
   always_ff @(posedge clk) begin
      r_state <= !rstn ? IDLE : w_state_nx;
   end
   always_comb begin
      w_state_nx = r_state;
      if (r_state == IDLE) w_state_nx = w_csn_fall ? ADDR : IDLE;
      else if (w_csn_rise) w_state_nx = IDLE;
      else if (w_hdr_done) w_state_nx = DATA;
   end
   always_comb begin
      busy        = r_state != IDLE;
      w_sample    = w_sclk_rise && r_state != IDLE;
      w_last      = r_state == ADDR ? r_cnt == CW'(ADDR_WIDTH - 1) : r_cnt == CW'(DATA_WIDTH - 1);
      w_hdr_done  = w_sample && r_state == ADDR && w_last;
      w_word_done = w_sample && r_state == DATA && w_last;
      // a last bit landing with the csn rise still completes its word, so it is not an abort
      w_abort     = w_csn_rise && r_state != IDLE && (w_sample ? !w_last : r_cnt != '0);
      w_load      = w_word_done && (!r_valid || wr.wr_ready);
      w_drop      = w_word_done && r_valid && !wr.wr_ready;
      w_shift_nx  = {r_shift[DATA_WIDTH-2:0], w_mosi};
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_cnt   <= '0;
         r_shift <= '0;
         r_ptr   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_abort <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_cnt   <= (r_state == IDLE || w_csn_rise) ? '0 : w_sample ? (w_last ? '0 : r_cnt + 1'b1) : r_cnt;
         if (w_sample) r_shift <= w_shift_nx;
         r_ptr   <= w_hdr_done ? w_shift_nx[ADDR_WIDTH-1:0] : w_word_done ? r_ptr + 1'b1 : r_ptr;
         r_valid <= w_load | (r_valid & ~wr.wr_ready);
         if (w_load) begin
            r_addr <= r_ptr;
            r_data <= w_shift_nx;
         end
         r_abort <= w_abort;
         r_ovf   <= w_drop | (r_ovf & ~clr_status);
      end
   end
   assign wr.wr_addr  = r_addr;
   assign wr.wr_data  = r_data;
   assign wr.wr_valid = r_valid;
   assign abort_pulse = r_abort;
   assign overflow    = r_ovf;
`ifdef SPI_STATUS_COUNTERS_EN
   logic [7:0] r_abort_cnt, r_ovf_cnt;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_abort_cnt <= '0;
         r_ovf_cnt   <= '0;
      end else begin
         r_abort_cnt <= clr_status ? {7'd0, w_abort} : (w_abort && r_abort_cnt != 8'hFF) ? r_abort_cnt + 1'b1 : r_abort_cnt;
         r_ovf_cnt   <= clr_status ? {7'd0, w_drop} : (w_drop && r_ovf_cnt != 8'hFF) ? r_ovf_cnt + 1'b1 : r_ovf_cnt;
      end
   end
   assign abort_count    = r_abort_cnt;
   assign overflow_count = r_ovf_cnt;
`endif
endmodule

// File: tb/tb_spi_write_sequencer.sv
// tb_spi_write_sequencer: directed and randomized frames checked against a transaction-queue model of the write port.
module tb_spi_write_sequencer;
   logic clk = 1'b0, rstn = 1'b0, sclk_in = 1'b0, mosi_in = 1'b0, csn_in = 1'b1, clr_status = 1'b0;
   logic busy, abort_pulse, overflow;
`ifdef SPI_STATUS_COUNTERS_EN
   logic [7:0] abort_count, overflow_count;
`endif
   spi_write_sequencer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) wr ();
   spi_write_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rstn(rstn), .sclk_in(sclk_in), .mosi_in(mosi_in), .csn_in(csn_in),
      .clr_status(clr_status), .wr(wr), .busy(busy), .abort_pulse(abort_pulse), .overflow(overflow)
`ifdef SPI_STATUS_COUNTERS_EN
      , .abort_count(abort_count), .overflow_count(overflow_count)
`endif
   );
   always #5 clk = ~clk;
   typedef struct packed {logic [7:0] a; logic [31:0] d;} txn_t;
   txn_t exp_q[$];
   txn_t t;
   int checks = 0, errors = 0, n_xfer = 0, n_abort = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (abort_pulse) n_abort++;
      if (rstn && wr.wr_valid && wr.wr_ready) begin
         n_xfer++;
         chk("xfer_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            chk("xfer_addr", 64'(wr.wr_addr), 64'(t.a));
            chk("xfer_data", 64'(wr.wr_data), 64'(t.d));
         end
      end
   end
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi_in = v[i];
         tick(3);
         sclk_in = 1'b1;
         tick(3);
         sclk_in = 1'b0;
      end
   endtask
   task automatic frame_start();
      csn_in = 1'b0;
      tick(6);
   endtask
   task automatic frame_end();
      tick(6);
      csn_in = 1'b1;
      tick(10);
   endtask
   task automatic send_word(input logic [7:0] a, input logic [31:0] d);
      exp_q.push_back(txn_t'({a, d}));
      send_bits(d, 32);
   endtask
   initial begin
      int a0, x0, nh, nw, extra;
      logic [7:0] hdr;
      logic [31:0] d;
      wr.wr_ready = 1'b1;
      tick(4);
      chk("rst_valid", 64'(wr.wr_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_abort", 64'(abort_pulse), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_addr_data", 64'({wr.wr_addr, wr.wr_data}), 64'd0);
`ifdef SPI_STATUS_COUNTERS_EN
      chk("rst_counts", 64'({abort_count, overflow_count}), 64'd0);
`endif
      rstn = 1'b1;
      tick(6);
      a0 = n_abort; x0 = n_xfer;
      frame_start();
      chk("busy_in_frame", 64'(busy), 64'd1);
      send_bits(32'h10, 8);
      send_word(8'h10, 32'hDEADBEEF);
      frame_end();
      chk("t1_busy_after", 64'(busy), 64'd0);
      chk("t1_no_abort", 64'(n_abort - a0), 64'd0);
      chk("t1_xfers", 64'(n_xfer - x0), 64'd1);
      x0 = n_xfer;
      frame_start();
      send_bits(32'hFF, 8);
      for (int i = 1; i <= 3; i++) send_word(8'(8'hFF + i - 1), 32'(i));
      frame_end();
      chk("t2_xfers", 64'(n_xfer - x0), 64'd3);
      chk("t2_drained", 64'(exp_q.size()), 64'd0);
      wr.wr_ready = 1'b0;
      frame_start();
      send_bits(32'h30, 8);
      send_bits(32'hAAAA0000, 32);
      send_bits(32'h5555FFFF, 32);
      frame_end();
      chk("t3_held_valid", 64'(wr.wr_valid), 64'd1);
      chk("t3_held_txn", 64'({wr.wr_addr, wr.wr_data}), 64'h30AAAA0000);
      chk("t3_ovf", 64'(overflow), 64'd1);
`ifdef SPI_STATUS_COUNTERS_EN
      chk("t3_ovf_count", 64'(overflow_count), 64'd1);
`endif
      exp_q.push_back(txn_t'({8'h30, 32'hAAAA0000}));
      x0 = n_xfer;
      wr.wr_ready = 1'b1;
      tick(1);
      chk("t3_valid_drop", 64'(wr.wr_valid), 64'd0);
      tick(4);
      chk("t3_one_xfer", 64'(n_xfer - x0), 64'd1);
      chk("t3_ovf_sticky", 64'(overflow), 64'd1);
      clr_status = 1'b1;
      tick(1);
      clr_status = 1'b0;
      chk("t3_ovf_clr", 64'(overflow), 64'd0);
`ifdef SPI_STATUS_COUNTERS_EN
      chk("t3_ovf_count_clr", 64'(overflow_count), 64'd0);
`endif
      a0 = n_abort; x0 = n_xfer;
      frame_start();
      send_bits(32'h20, 8);
      send_bits(32'h1ABC, 13);
      frame_end();
      chk("t4_abort", 64'(n_abort - a0), 64'd1);
      chk("t4_no_xfer", 64'(n_xfer - x0), 64'd0);
      frame_start();
      send_bits(32'h21, 8);
      send_word(8'h21, 32'h12345678);
      frame_end();
      chk("t4_next_xfer", 64'(n_xfer - x0), 64'd1);
      a0 = n_abort; x0 = n_xfer;
      frame_start();
      send_bits(32'h40, 8);
      send_bits(32'h3FF, 10);
      rstn = 1'b0;
      tick(2);
      rstn = 1'b1;
      send_bits(32'h155, 10);
      tick(4);
      chk("t5_busy", 64'(busy), 64'd0);
      send_bits(32'h2AAAAA, 22);
      tick(6);
      chk("t5_valid", 64'(wr.wr_valid), 64'd0);
      chk("t5_busy2", 64'(busy), 64'd0);
      csn_in = 1'b1;
      tick(10);
      chk("t5_no_abort", 64'(n_abort - a0), 64'd0);
      chk("t5_no_xfer", 64'(n_xfer - x0), 64'd0);
      d = $urandom;
      frame_start();
      send_bits(32'h41, 8);
      send_word(8'h41, d);
      frame_end();
      chk("t5_new_frame", 64'(n_xfer - x0), 64'd1);
      a0 = n_abort;
      frame_start();
      frame_end();
      chk("empty_frame_no_abort", 64'(n_abort - a0), 64'd0);
      for (int f = 0; f < 8; f++) begin
         hdr = 8'($urandom);
         nh = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
         nw = nh == 8 ? $urandom_range(0, 2) : 0;
         extra = (nh == 8 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 31) : 0;
         a0 = n_abort; x0 = n_xfer;
         frame_start();
         send_bits(32'(hdr) >> (8 - nh), nh);
         for (int i = 0; i < nw; i++) send_word(8'(hdr + i), $urandom);
         send_bits($urandom, extra);
         frame_end();
         chk("rnd_abort", 64'(n_abort - a0), 64'((nh != 8 || extra != 0) ? 1 : 0));
         chk("rnd_xfers", 64'(n_xfer - x0), 64'(nw));
         chk("rnd_busy", 64'(busy), 64'd0);
      end
      chk("all_drained", 64'(exp_q.size()), 64'd0);
`ifdef SPI_STATUS_COUNTERS_EN
      clr_status = 1'b1;
      tick(1);
      clr_status = 1'b0;
      a0 = n_abort;
      for (int f = 0; f < 300; f++) begin
         frame_start();
         send_bits(32'h5, 3);
         frame_end();
      end
      chk("cnt_aborts_seen", 64'(n_abort - a0), 64'd300);
      chk("cnt_saturate", 64'(abort_count), 64'd255);
      clr_status = 1'b1;
      tick(1);
      clr_status = 1'b0;
      chk("cnt_clr", 64'(abort_count), 64'd0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
